sme_req_arbiter: RTL and testbench

- Shares one pigasus_sme_wrapper instance between PORTS requesters (RISC-V core slots) on a per-packet basis.
- Grants a requester round-robin, latches its metadata for the whole packet, and forwards its data stream.
- Records the packet order in an ID FIFO and routes each match burst and each preamble state-out back to the requester that owns the packet.

---
 rtl/sme_req_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_sme_req_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_req_arbiter.sv
// sme_req_arbiter: shares one pattern-matching engine between PORTS requesters.
// A requester is granted round-robin for a whole packet. Its metadata is held
// for the packet and its data stream is forwarded. The owner of each accepted
// packet is queued so match bursts and state-out strobes are routed back to it.
module sme_req_arbiter #(
    parameter int PORTS         = 4,
    parameter int BYTE_COUNT    = 16,
    parameter int STRB_COUNT    = $clog2(BYTE_COUNT),
    parameter int ID_FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PORTS*BYTE_COUNT*8-1:0]    s_axis_tdata,
    input  logic [PORTS*STRB_COUNT-1:0]      s_axis_tempty,
    input  logic [PORTS-1:0]                 s_axis_tvalid,
    input  logic [PORTS-1:0]                 s_axis_tlast,
    output logic [PORTS-1:0]                 s_axis_tready,
    input  logic [PORTS*64-1:0]              s_preamble_state,
    input  logic [PORTS*16-1:0]              s_src_port,
    input  logic [PORTS*16-1:0]              s_dst_port,
    input  logic [PORTS-1:0]                 s_meta_valid,
    output logic [PORTS-1:0]                 s_meta_ready,
    output logic [BYTE_COUNT*8-1:0]          m_axis_tdata,
    output logic [STRB_COUNT-1:0]            m_axis_tempty,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic [63:0]                      m_preamble_state,
    output logic [15:0]                      m_src_port,
    output logic [15:0]                      m_dst_port,
    output logic                             m_meta_valid,
    input  logic                             m_meta_ready,
    input  logic [31:0]                      sme_match_rules_ID,
    input  logic                             sme_match_last,
    input  logic                             sme_match_valid,
    output logic                             sme_match_release,
    input  logic [63:0]                      sme_state_out,
    input  logic                             sme_state_out_valid,
    output logic [31:0]                      match_rules_ID,
    output logic                             match_last,
    output logic [PORTS-1:0]                 match_valid,
    input  logic [PORTS-1:0]                 match_release,
    output logic [63:0]                      state_out,
    output logic [PORTS-1:0]                 state_out_valid,
    output logic                             err_no_owner
);

    localparam int DW = BYTE_COUNT * 8;
    localparam int GW = $clog2(PORTS);
    localparam int AW = $clog2(ID_FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_META,
        ST_DATA
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_gnt;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_last_owner;
    logic [63:0]     r_meta_state;
    logic [15:0]     r_meta_src;
    logic [15:0]     r_meta_dst;

    logic [GW-1:0]   r_fifo_mem [ID_FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_err_no_owner;

    wire  [DW-1:0]         w_lane_tdata  [PORTS];
    wire  [STRB_COUNT-1:0] w_lane_tempty [PORTS];
    wire  [63:0]           w_lane_state  [PORTS];
    wire  [15:0]           w_lane_src    [PORTS];
    wire  [15:0]           w_lane_dst    [PORTS];

    logic            w_any_req;
    logic [GW-1:0]   w_pick;
    logic [GW:0]     w_sum;
    logic [GW-1:0]   w_next_ptr;
    logic [PORTS-1:0] w_gnt_oh;
    logic [PORTS-1:0] w_head_oh;
    logic [PORTS-1:0] w_last_oh;
    logic [GW-1:0]   w_head;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_push;
    logic            w_pop;
    logic            w_beat_last;

    // Split the flat per-requester buses into indexable lanes
    for (genvar g = 0; g < PORTS; g++) begin : g_lane
        assign w_lane_tdata[g]  = s_axis_tdata[g*DW +: DW];
        assign w_lane_tempty[g] = s_axis_tempty[g*STRB_COUNT +: STRB_COUNT];
        assign w_lane_state[g]  = s_preamble_state[g*64 +: 64];
        assign w_lane_src[g]    = s_src_port[g*16 +: 16];
        assign w_lane_dst[g]    = s_dst_port[g*16 +: 16];
    end

    // Round-robin search: first requesting port at or after r_rr_ptr, wrapping
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        w_sum     = '0;
        for (int i = 0; i < PORTS; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
            if (w_sum >= (GW+1)'(PORTS)) begin
                w_sum = w_sum - (GW+1)'(PORTS);
            end
            if (!w_any_req && s_meta_valid[w_sum[GW-1:0]]) begin
                w_any_req = 1'b1;
                w_pick    = w_sum[GW-1:0];
            end
        end
    end

    assign w_next_ptr   = (r_gnt == GW'(PORTS - 1)) ? '0 : r_gnt + GW'(1);
    assign w_gnt_oh     = PORTS'(1) << r_gnt;
    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_head_oh    = PORTS'(1) << w_head;
    assign w_last_oh    = PORTS'(1) << r_last_owner;
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CW'(ID_FIFO_DEPTH));

    // Data path follows the granted requester only while a packet is open
    assign m_axis_tdata  = w_lane_tdata[r_gnt];
    assign m_axis_tempty = w_lane_tempty[r_gnt];
    assign m_axis_tvalid = (r_state == ST_DATA) && s_axis_tvalid[r_gnt];
    assign m_axis_tlast  = (r_state == ST_DATA) && s_axis_tlast[r_gnt];
    assign s_axis_tready = ((r_state == ST_DATA) && m_axis_tready) ? w_gnt_oh : '0;
    assign w_beat_last   = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Metadata stays on the bus for the whole packet since the engine samples it per beat
    assign m_meta_valid     = (r_state == ST_META);
    assign m_preamble_state = r_meta_state;
    assign m_src_port       = r_meta_src;
    assign m_dst_port       = r_meta_dst;
    assign s_meta_ready     = ((r_state == ST_META) && m_meta_ready) ? w_gnt_oh : '0;

    // State-out arrives the cycle after tlast, when r_last_owner already points at the packet
    assign state_out       = sme_state_out;
    assign state_out_valid = sme_state_out_valid ? w_last_oh : '0;

    // Match bursts go to the owner at the head of the ID queue
    assign match_rules_ID    = sme_match_rules_ID;
    assign match_last        = sme_match_last;
    assign match_valid       = (sme_match_valid && !w_fifo_empty) ? w_head_oh : '0;
    assign sme_match_release = match_release[w_head] && !w_fifo_empty;
    assign err_no_owner      = r_err_no_owner;

    assign w_push = (r_state == ST_META) && m_meta_ready;
    assign w_pop  = sme_match_valid && sme_match_release && sme_match_last;

    // Packet FSM: grant, present metadata, then forward data until tlast
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_rr_ptr     <= '0;
            r_last_owner <= '0;
            r_meta_state <= '0;
            r_meta_src   <= '0;
            r_meta_dst   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_full && w_any_req) begin
                        r_gnt        <= w_pick;
                        r_meta_state <= w_lane_state[w_pick];
                        r_meta_src   <= w_lane_src[w_pick];
                        r_meta_dst   <= w_lane_dst[w_pick];
                        r_state      <= ST_META;
                    end
                end
                ST_META: begin
                    if (m_meta_ready) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat_last) begin
                        r_last_owner <= r_gnt;
                        r_rr_ptr     <= w_next_ptr;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ID queue pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ID queue storage holds the owner index of each accepted packet
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= r_gnt;
        end
    end

    // Sticky flag for a match burst that has no recorded owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_no_owner <= 1'b0;
        end else if (sme_match_valid && w_fifo_empty) begin
            r_err_no_owner <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sme_req_arbiter.sv
// Bench for sme_req_arbiter: directed sequence with random payloads, checked
// against a packet-level model (owner queue plus round-robin pointer).
module tb_sme_req_arbiter;

    localparam int PORTS = 4;
    localparam int BC    = 16;
    localparam int SC    = $clog2(BC);
    localparam int DEPTH = 8;
    localparam int DW    = BC * 8;

    logic clk;
    logic rst_n;

    wire  [PORTS*DW-1:0]  s_axis_tdata;
    wire  [PORTS*SC-1:0]  s_axis_tempty;
    logic [PORTS-1:0]     s_axis_tvalid;
    logic [PORTS-1:0]     s_axis_tlast;
    logic [PORTS-1:0]     s_axis_tready;
    wire  [PORTS*64-1:0]  s_preamble_state;
    wire  [PORTS*16-1:0]  s_src_port;
    wire  [PORTS*16-1:0]  s_dst_port;
    logic [PORTS-1:0]     s_meta_valid;
    logic [PORTS-1:0]     s_meta_ready;
    logic [DW-1:0]        m_axis_tdata;
    logic [SC-1:0]        m_axis_tempty;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;
    logic [63:0]          m_preamble_state;
    logic [15:0]          m_src_port;
    logic [15:0]          m_dst_port;
    logic                 m_meta_valid;
    logic                 m_meta_ready;
    logic [31:0]          sme_match_rules_ID;
    logic                 sme_match_last;
    logic                 sme_match_valid;
    logic                 sme_match_release;
    logic [63:0]          sme_state_out;
    logic                 sme_state_out_valid;
    logic [31:0]          match_rules_ID;
    logic                 match_last;
    logic [PORTS-1:0]     match_valid;
    logic [PORTS-1:0]     match_release;
    logic [63:0]          state_out;
    logic [PORTS-1:0]     state_out_valid;
    logic                 err_no_owner;

    logic [DW-1:0] ld [PORTS];
    logic [SC-1:0] le [PORTS];
    logic [63:0]   st [PORTS];
    logic [15:0]   sp [PORTS];
    logic [15:0]   dp [PORTS];

    for (genvar g = 0; g < PORTS; g++) begin : g_pack
        assign s_axis_tdata[g*DW +: DW]     = ld[g];
        assign s_axis_tempty[g*SC +: SC]    = le[g];
        assign s_preamble_state[g*64 +: 64] = st[g];
        assign s_src_port[g*16 +: 16]       = sp[g];
        assign s_dst_port[g*16 +: 16]       = dp[g];
    end

    sme_req_arbiter #(
        .PORTS(PORTS), .BYTE_COUNT(BC), .STRB_COUNT(SC), .ID_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tempty(s_axis_tempty),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .s_preamble_state(s_preamble_state), .s_src_port(s_src_port),
        .s_dst_port(s_dst_port), .s_meta_valid(s_meta_valid),
        .s_meta_ready(s_meta_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tempty(m_axis_tempty),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .m_preamble_state(m_preamble_state), .m_src_port(m_src_port),
        .m_dst_port(m_dst_port), .m_meta_valid(m_meta_valid),
        .m_meta_ready(m_meta_ready),
        .sme_match_rules_ID(sme_match_rules_ID), .sme_match_last(sme_match_last),
        .sme_match_valid(sme_match_valid), .sme_match_release(sme_match_release),
        .sme_state_out(sme_state_out), .sme_state_out_valid(sme_state_out_valid),
        .match_rules_ID(match_rules_ID), .match_last(match_last),
        .match_valid(match_valid), .match_release(match_release),
        .state_out(state_out), .state_out_valid(state_out_valid),
        .err_no_owner(err_no_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int q[$];      // owners of accepted packets, in acceptance order
    int rr = 0;    // model of the round-robin start point

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PORTS-1:0] oh(input int p);
        return PORTS'(1) << p;
    endfunction

    function automatic int pick(input int r, input logic [PORTS-1:0] m);
        for (int k = 0; k < PORTS; k++) begin
            int c;
            c = (r + k) % PORTS;
            if (((m >> c) & PORTS'(1)) != '0) return c;
        end
        return 0;
    endfunction

    task automatic new_meta(input int p);
        st[p] = {$urandom, $urandom};
        sp[p] = 16'($urandom);
        dp[p] = 16'($urandom);
    endtask

    task automatic new_lanes();
        for (int p = 0; p < PORTS; p++) begin
            ld[p] = {$urandom, $urandom, $urandom, $urandom};
            le[p] = SC'($urandom);
        end
    endtask

    task automatic wait_meta(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (m_meta_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("meta_timeout", 128'(m_meta_valid), 128'(1));
    endtask

    task automatic match_beat(input logic [31:0] id, input bit last, input logic [PORTS-1:0] rel);
        logic [PORTS-1:0] exp_mv;
        bit exp_rel;
        @(negedge clk);
        sme_match_valid    = 1'b1;
        sme_match_rules_ID = id;
        sme_match_last     = last;
        match_release      = rel;
        #1;
        exp_mv  = '0;
        exp_rel = 1'b0;
        if (q.size() > 0) begin
            exp_mv  = oh(q[0]);
            exp_rel = ((rel >> q[0]) & PORTS'(1)) != '0;
        end
        check("match_valid", 128'(match_valid), 128'(exp_mv));
        check("match_release", 128'(sme_match_release), 128'(exp_rel));
        check("match_id", 128'(match_rules_ID), 128'(id));
        check("match_last", 128'(match_last), 128'(last));
        if (exp_rel && last) void'(q.pop_front());
    endtask

    task automatic match_clear();
        @(negedge clk);
        sme_match_valid = 1'b0;
        sme_match_last  = 1'b0;
        match_release   = '0;
    endtask

    // One packet: wait for the grant, accept meta (optionally with a match pop in
    // the same cycle), one stalled cycle, nbeats beats, then state-out and bubble.
    task automatic run_pkt(input int req, input int nbeats, input bit keep, input bit with_pop);
        int g;
        bit ok;
        @(negedge clk);
        if (req >= 0) s_meta_valid = s_meta_valid | oh(req);
        wait_meta(ok);
        if (!ok) return;
        g = pick(rr, s_meta_valid);
        check("meta_state", 128'(m_preamble_state), 128'(st[g]));
        check("meta_src", 128'(m_src_port), 128'(sp[g]));
        check("meta_dst", 128'(m_dst_port), 128'(dp[g]));
        m_meta_ready = 1'b1;
        if (with_pop) begin
            sme_match_valid    = 1'b1;
            sme_match_last     = 1'b1;
            sme_match_rules_ID = $urandom;
            match_release      = oh(q[0]);
        end
        #1;
        check("meta_ready", 128'(s_meta_ready), 128'(oh(g)));
        if (with_pop) begin
            check("pp_route", 128'(match_valid), 128'(oh(q[0])));
            check("pp_release", 128'(sme_match_release), 128'(1));
            void'(q.pop_front());
        end
        @(negedge clk);
        m_meta_ready    = 1'b0;
        sme_match_valid = 1'b0;
        sme_match_last  = 1'b0;
        match_release   = '0;
        q.push_back(g);
        if (!keep) s_meta_valid = s_meta_valid & ~oh(g);
        new_lanes();
        s_axis_tvalid = '1;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        #1;
        check("stall_tready", 128'(s_axis_tready), 128'(0));
        check("stall_tvalid", 128'(m_axis_tvalid), 128'(1));
        check("meta_ready_once", 128'(s_meta_ready), 128'(0));
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            new_lanes();
            s_axis_tlast  = (b == nbeats - 1) ? oh(g) : '0;
            m_axis_tready = 1'b1;
            #1;
            check("beat_data", 128'(m_axis_tdata), 128'(ld[g]));
            check("beat_empty", 128'(m_axis_tempty), 128'(le[g]));
            check("beat_last", 128'(m_axis_tlast), 128'(b == nbeats - 1));
            check("beat_tready", 128'(s_axis_tready), 128'(oh(g)));
            check("beat_state", 128'(m_preamble_state), 128'(st[g]));
        end
        @(negedge clk);
        s_axis_tvalid       = '0;
        s_axis_tlast        = '0;
        m_axis_tready       = 1'b0;
        sme_state_out_valid = 1'b1;
        sme_state_out       = {$urandom, $urandom};
        #1;
        rr = (g + 1) % PORTS;
        check("idle_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("bubble", 128'(m_meta_valid), 128'(0));
        check("so_valid", 128'(state_out_valid), 128'(oh(g)));
        check("so_data", 128'(state_out), 128'(sme_state_out));
        @(negedge clk);
        sme_state_out_valid = 1'b0;
        #1;
        check("next_grant", 128'(m_meta_valid), 128'((s_meta_valid != '0) && (q.size() < DEPTH)));
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        s_axis_tvalid = '0; s_axis_tlast = '0; s_meta_valid = '0;
        m_axis_tready = 1'b0; m_meta_ready = 1'b0;
        sme_match_rules_ID = '0; sme_match_last = 1'b0; sme_match_valid = 1'b0;
        sme_state_out = '0; sme_state_out_valid = 1'b0; match_release = '0;
        for (int p = 0; p < PORTS; p++) new_meta(p);
        new_lanes();
        repeat (2) @(negedge clk);
        #1;
        check("rst_meta_valid", 128'(m_meta_valid), 128'(0));
        check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("rst_tready", 128'(s_axis_tready), 128'(0));
        check("rst_meta_ready", 128'(s_meta_ready), 128'(0));
        check("rst_match_valid", 128'(match_valid), 128'(0));
        check("rst_err", 128'(err_no_owner), 128'(0));
        check("rst_meta_regs", 128'(m_preamble_state), 128'(0));
        rst_n = 1'b1;

        // Single requester 1, 3-beat packet, then its match burst
        st[1] = 64'h0100_0000_0000_0000;
        run_pkt(1, 3, 1'b0, 1'b0);
        match_beat(32'd5, 1'b0, oh(2));
        match_beat(32'd5, 1'b0, oh(1));
        match_beat(32'd9, 1'b1, oh(1));
        match_clear();

        // Reset in the middle of a packet
        new_meta(2);
        @(negedge clk);
        s_meta_valid = oh(2);
        wait_meta(ok);
        m_meta_ready = 1'b1;
        @(negedge clk);
        m_meta_ready  = 1'b0;
        s_meta_valid  = '0;
        s_axis_tvalid = '1;
        m_axis_tready = 1'b1;
        #1;
        check("pre_rst_tvalid", 128'(m_axis_tvalid), 128'(1));
        rst_n = 1'b0;
        #1;
        check("async_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("async_tready", 128'(s_axis_tready), 128'(0));
        check("async_meta", 128'(m_meta_valid), 128'(0));
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        q.delete();
        rr = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters continuously; grants rotate from requester 0
        for (int p = 0; p < PORTS; p++) new_meta(p);
        s_meta_valid = '1;
        for (int k = 0; k < DEPTH; k++) run_pkt(-1, 1 + int'($urandom_range(0, 1)), 1'b1, 1'b0);

        // Queue full: no grant until one burst is released
        s_meta_valid = oh(2);
        repeat (4) begin
            @(negedge clk); #1;
            check("full_hold", 128'(m_meta_valid), 128'(0));
        end
        match_beat($urandom, 1'b1, oh(q[0]));
        match_clear();
        #1;
        check("pop_no_grant_yet", 128'(m_meta_valid), 128'(0));
        @(negedge clk); #1;
        check("grant_after_pop", 128'(m_meta_valid), 128'(1));
        run_pkt(-1, 2, 1'b0, 1'b0);

        // Drain down to three outstanding packets
        match_beat($urandom, 1'b0, ~oh(q[0]));
        for (int k = 0; k < 5; k++) begin
            match_beat($urandom, 1'b0, oh(q[0]));
            match_beat($urandom, 1'b1, oh(q[0]));
        end
        match_clear();

        // Push and pop in the same cycle, then drain the remaining three
        new_meta(3);
        run_pkt(3, 1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) match_beat($urandom, 1'b1, oh(q[0]));
        match_clear();
        #1;
        check("err_before", 128'(err_no_owner), 128'(0));

        // Match with no owner on record
        match_beat($urandom, 1'b0, '1);
        match_clear();
        #1;
        check("err_set", 128'(err_no_owner), 128'(1));
        @(negedge clk); #1;
        check("err_sticky", 128'(err_no_owner), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
